// File: rtl/node_accum.sv
`default_nettype none
// ============================================================================
// Module      : node_accum
// Description : Streaming dot-product accumulator with threshold decision and
//               term-count check. Optional macro NODE_ACCUM_ERRCNT_EN adds a
//               saturating 8-bit count of length errors on err_count.
// Revision    : 1.0 - initial release
// ============================================================================
module node_accum #(
  parameter int WIDTH_P = 15,
  parameter int N_TERMS = 8,
  localparam int WIDTH_ACC = WIDTH_P + $clog2(N_TERMS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        p_valid,
  input  logic signed [WIDTH_P-1:0]   p,
  input  logic                        p_last,
  output logic                        p_ready,
  input  logic signed [WIDTH_ACC-1:0] threshold,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH_ACC-1:0] sum_out,
  output logic                        decision,
  output logic                        err_len,
  output logic [7:0]                  err_count
);

  localparam int c_CNT_W = $clog2(N_TERMS + 1);
  localparam logic [c_CNT_W-1:0] c_N_TERMS = c_CNT_W'(N_TERMS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                      r_state;
  logic signed [WIDTH_ACC-1:0] r_acc;
  logic signed [WIDTH_ACC-1:0] r_sum;
  logic [c_CNT_W-1:0]          r_count;
  logic                        r_out_valid;
  logic                        r_decision;
  logic                        r_err_len;

  logic                        w_accept;
  logic                        w_cont;
  logic                        w_full;
  logic                        w_done;
  logic                        w_err;
  logic signed [WIDTH_ACC-1:0] w_p_ext;
  logic signed [WIDTH_ACC-1:0] w_new_acc;
  logic [c_CNT_W-1:0]          w_new_cnt;

  assign p_ready   = (r_state == S_HOLD) ? out_ready : 1'b1;
  assign w_accept  = p_valid & p_ready;
  assign w_cont    = (r_state == S_ACCUM);
  assign w_p_ext   = {{(WIDTH_ACC-WIDTH_P){p[WIDTH_P-1]}}, p};
  // A term taken in IDLE or HOLD starts a fresh vector from zero.
  assign w_new_acc = (w_cont ? r_acc : '0) + w_p_ext;
  assign w_new_cnt = (w_cont ? r_count : '0) + c_CNT_W'(1);
  assign w_full    = (w_new_cnt == c_N_TERMS);
  assign w_done    = p_last | w_full;
  // Clean only when p_last lands exactly on the N-th term.
  assign w_err     = p_last ^ w_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
      r_decision  <= 1'b0;
      r_err_len   <= 1'b0;
    end else if (w_accept) begin
      if (w_done) begin
        r_sum       <= w_new_acc;
        r_decision  <= (w_new_acc > threshold);
        r_err_len   <= w_err;
        r_out_valid <= 1'b1;
        r_acc       <= '0;
        r_count     <= '0;
        r_state     <= S_HOLD;
      end else begin
        r_acc       <= w_new_acc;
        r_count     <= w_new_cnt;
        r_out_valid <= 1'b0;
        r_state     <= S_ACCUM;
      end
    end else if ((r_state == S_HOLD) && out_ready) begin
      r_out_valid <= 1'b0;
      r_state     <= S_IDLE;
    end
  end

  assign out_valid = r_out_valid;
  assign sum_out   = r_sum;
  assign decision  = r_decision;
  assign err_len   = r_err_len;

`ifdef NODE_ACCUM_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_count <= 8'd0;
    end else if (w_accept && w_done && w_err && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_node_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_node_accum
// Description : Scoreboard bench for node_accum (directed + random vectors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_node_accum;

  localparam int WP  = 15;
  localparam int N   = 8;
  localparam int WA  = 18;

  logic                 clk;
  logic                 reset;
  logic                 p_valid;
  logic signed [WP-1:0] p;
  logic                 p_last;
  logic                 p_ready;
  logic signed [WA-1:0] threshold;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [WA-1:0] sum_out;
  logic                 decision;
  logic                 err_len;
  logic [7:0]           err_count;

  node_accum #(.WIDTH_P(WP), .N_TERMS(N)) dut (
    .clk(clk), .reset(reset), .p_valid(p_valid), .p(p), .p_last(p_last),
    .p_ready(p_ready), .threshold(threshold), .out_valid(out_valid),
    .out_ready(out_ready), .sum_out(sum_out), .decision(decision),
    .err_len(err_len), .err_count(err_count)
  );

  typedef struct {
    longint sum;
    longint dec;
    longint err;
    longint ec;
  } exp_t;

  exp_t   sbq[$];
  int     terms[$];
  bit     m_hold;
  bit     m_acc;
  int     m_ec;
  bit     rnd_rdy;
  int     errors;
  int     checks;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects accepted terms and predicts each result.
  initial begin
    longint s;
    bit     exp_rdy;
    bit     err;
    exp_t   e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        terms.delete();
        sbq.delete();
        m_hold = 1'b0;
        m_acc  = 1'b0;
        m_ec   = 0;
      end else begin
        exp_rdy = m_hold ? out_ready : 1'b1;
        chk("p_ready", longint'(p_ready), longint'(exp_rdy));
        chk("out_valid", longint'(out_valid), longint'(m_hold));
        m_acc = p_valid && exp_rdy;
        if (m_hold && out_ready) m_hold = 1'b0;
        if (m_acc) begin
          terms.push_back(int'(p));
          if (p_last || terms.size() == N) begin
            s = 0;
            foreach (terms[i]) s += terms[i];
            err = !(p_last && terms.size() == N);
`ifdef NODE_ACCUM_ERRCNT_EN
            if (err && m_ec < 255) m_ec++;
`endif
            e.sum = s;
            e.dec = (s > longint'(threshold)) ? 1 : 0;
            e.err = err ? 1 : 0;
            e.ec  = m_ec;
            sbq.push_back(e);
            terms.delete();
            m_hold = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: compares whatever the DUT holds against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && out_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got sum_out %0d expected no result", sum_out);
        end else begin
          e = sbq[0];
          chk("sum_out", longint'(sum_out), e.sum);
          chk("decision", longint'(decision), e.dec);
          chk("err_len", longint'(err_len), e.err);
          chk("err_count", longint'(err_count), e.ec);
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic rnd_ready();
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input int v, input bit last, input longint thr);
    p_valid   = 1'b1;
    p         = WP'(v);
    p_last    = last;
    threshold = WA'(thr);
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      if (m_acc) begin
        #1;
        p_valid = 1'b0;
        p_last  = 1'b0;
        rnd_ready();
        return;
      end
      #1;
      rnd_ready();
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: got no acceptance expected acceptance within 64 cycles");
    p_valid = 1'b0;
    p_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      p_valid = 1'b0;
      p_last  = 1'b0;
      rnd_ready();
    end
  endtask

  task automatic reset_checks();
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_sum_out", longint'(sum_out), 0);
    chk("rst_decision", longint'(decision), 0);
    chk("rst_err_len", longint'(err_len), 0);
    chk("rst_err_count", longint'(err_count), 0);
    chk("rst_p_ready", longint'(p_ready), 1);
  endtask

  initial begin
    int     len;
    longint thr;
    errors    = 0;
    checks    = 0;
    rnd_rdy   = 1'b0;
    reset     = 1'b0;
    p_valid   = 1'b0;
    p         = '0;
    p_last    = 1'b0;
    threshold = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks();
    @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 8; i++) send(100, i == 7, 700);
    idle(3);
    for (int i = 0; i < 8; i++) send(100, i == 7, 800);
    idle(3);
    for (int i = 0; i < 8; i++) send(-16384, i == 7, -131072);
    idle(3);
    send(5, 1'b0, 0);
    send(7, 1'b0, 0);
    send(-2, 1'b1, 0);
    idle(3);

    // Stall the consumer with the next term already waiting.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(100, i == 7, 0);
    p_valid = 1'b1;
    p       = WP'(37);
    p_last  = 1'b1;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    send(37, 1'b1, 0);
    idle(3);

    // Abort a vector half way with reset.
    for (int i = 0; i < 4; i++) send(1, 1'b0, 0);
    reset = 1'b0;
    @(negedge clk);
    reset_checks();
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 8; i++) send(1, i == 7, 0);
    idle(3);

    rnd_rdy = 1'b1;
    for (int v = 0; v < 250; v++) begin
      len = $urandom_range(1, 10);
      thr = longint'($urandom_range(0, 262143)) - 131072;
      for (int i = 0; i < len; i++) begin
        send(int'($urandom_range(0, 32767)) - 16384,
             (i == len - 1) && ($urandom_range(0, 5) != 0), thr);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rnd_rdy   = 1'b0;
    out_ready = 1'b1;
    idle(4);
    @(negedge clk);
    chk("scoreboard_drained", longint'(sbq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
